// File: rtl/ahb_uvc_slave_mem_pkg.sv
// ----------------------------------------------------------------------------
// ahb_uvc_pkg
// Shared AHB-Lite definitions for the AHB_UVC environment: transfer type,
// size and burst encodings, response constants, default bus widths and a
// small helper that turns an hsize code into a byte count.
// ----------------------------------------------------------------------------
package ahb_uvc_pkg;

  localparam int unsigned AHB_ADDR_WIDTH = 32;
  localparam int unsigned AHB_DATA_WIDTH = 32;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4WORD = 3'b100,
    HSIZE_8WORD = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Number of bytes moved by a transfer of the given hsize code.
  function automatic int unsigned hsize_bytes(input logic [2:0] hsize);
    return 32'd1 << hsize;
  endfunction

endpackage

// File: rtl/ahb_uvc_slave_mem_if.sv
// ----------------------------------------------------------------------------
// ahb_uvc_slave_mem_if
// AHB-Lite slave-side bus bundle.
//   master modport : drives address/control, hwdata and bus-level hready;
//                    observes hreadyout, hresp, hrdata.
//   slave  modport : the reverse.
// hclk and hreset are kept as plain ports on the modules.
// ----------------------------------------------------------------------------
interface ahb_uvc_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hburst;
  logic                  hmastlock;
  logic [3:0]            hprot;
  logic [2:0]            hsize;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, hburst, hmastlock, hprot, hsize, htrans, hwrite,
           hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, hburst, hmastlock, hprot, hsize, htrans, hwrite,
           hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_uvc_slave_mem_byte_lane_dec.sv
// ----------------------------------------------------------------------------
// ahb_uvc_byte_lane_dec
// Combinational byte-strobe decoder: marks the data-bus byte lanes touched
// by a transfer of size hsize starting at lane addr_lsb.
//   hsize    : transfer size code
//   addr_lsb : low address bits selecting the starting lane
//   strb     : one bit per byte lane, 1 = lane carries transfer data
// ----------------------------------------------------------------------------
module ahb_uvc_byte_lane_dec
  import ahb_uvc_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_LANES  = DATA_WIDTH / 8,
  localparam int LANE_BITS  = $clog2(NUM_LANES)
) (
  input  logic [2:0]           hsize,
  input  logic [LANE_BITS-1:0] addr_lsb,
  output logic [NUM_LANES-1:0] strb
);

  always_comb begin
    strb = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i >= int'(addr_lsb) &&
          i <  int'(addr_lsb) + int'(hsize_bytes(hsize))) begin
        strb[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_uvc_slave_mem.sv
// ----------------------------------------------------------------------------
// ahb_uvc_slave_mem
// AHB-Lite slave with an internal byte-addressable memory. Every legal
// transfer gets a data phase of WAIT_STATES+1 cycles; illegal transfers
// (out of range, misaligned, wider than the bus) get a two-cycle ERROR.
//   hclk   : bus clock
//   hreset : asynchronous active-high reset
//   bus    : slave modport of ahb_uvc_slave_mem_if (address/control,
//            hwdata, hready in; hreadyout, hresp, hrdata out)
// hburst, hmastlock and hprot are accepted but do not affect the response.
// ----------------------------------------------------------------------------
module ahb_uvc_slave_mem
  import ahb_uvc_pkg::*;
#(
  parameter int ADDR_WIDTH  = AHB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = AHB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic                hclk,
  input logic                hreset,
  ahb_uvc_slave_mem_if.slave bus
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NUM_LANES);
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("ahb_uvc_slave_mem: DATA_WIDTH must be 32 or 64");
  end
  if ((1 << MEM_AW) != MEM_DEPTH) begin : g_bad_mem_depth
    $error("ahb_uvc_slave_mem: MEM_DEPTH must be a power of two");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ahb_uvc_slave_mem: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic [MEM_AW-1:0]      addr_q;
  logic [2:0]             size_q;
  logic                   write_q;
  logic                   dphase_q, dphase_d;   // legal data phase in flight

  logic                   slot_open;            // slave can take an address phase
  logic                   accept;
  logic                   illegal;
  logic                   complete;             // completing OKAY cycle
  logic                   hreadyout_c, hresp_c;
  logic [NUM_LANES-1:0]   strb;
  logic [DATA_WIDTH-1:0]  rdata_word;
  logic [MEM_AW-LANE_BITS-1:0] word_idx;

  logic [7:0] mem [MEM_DEPTH];

  // --------------------------------------------------------------------------
  // Address phase acceptance and legality check
  // --------------------------------------------------------------------------
  assign slot_open = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     (state_q == ST_ERR2);

  assign accept = slot_open && bus.hsel && bus.hready &&
                  (bus.htrans == NONSEQ || bus.htrans == SEQ);

  // The misalignment mask only needs 7 address bits: hsize tops out at 128
  // bytes, and 7'd1 << 7 wraps to a full 7-bit mask after the subtraction.
  assign illegal = ((bus.haddr >> MEM_AW) != '0) ||
                   (|(bus.haddr[6:0] & ((7'd1 << bus.hsize) - 7'd1))) ||
                   (bus.hsize > 3'(LANE_BITS));

  // With WAIT_STATES=0 the completing cycle is an IDLE cycle with a data
  // phase still outstanding, so the flag rather than the state decides.
  assign complete = dphase_q && (state_q == ST_IDLE || state_q == ST_DONE);

  // --------------------------------------------------------------------------
  // FSM: state register and next-state/output logic
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      dphase_q   <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      dphase_q   <= dphase_d;
      if (accept) begin
        addr_q  <= bus.haddr[MEM_AW-1:0];
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  // NOTE: every signal written here is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dphase_d    = 1'b0;
    hreadyout_c = 1'b1;
    hresp_c     = HRESP_OKAY;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        hresp_c  = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        dphase_d = accept && !illegal;
        state_d  = ST_IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        hreadyout_c = 1'b0;
        dphase_d    = dphase_q;
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        hreadyout_c = 1'b0;
        hresp_c     = HRESP_ERROR;
        state_d     = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory: byte-lane writes and full-word reads of the registered address
  // --------------------------------------------------------------------------
  assign word_idx = addr_q[MEM_AW-1:LANE_BITS];

  ahb_uvc_byte_lane_dec #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_dec (
    .hsize    (size_q),
    .addr_lsb (addr_q[LANE_BITS-1:0]),
    .strb     (strb)
  );

  // NOTE: the memory array is deliberately left out of reset; only the
  // control path is reset, and a reset mid-phase clears complete so a
  // pending write can never commit.
  always_ff @(posedge hclk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (complete && write_q && strb[i]) begin
        mem[{word_idx, LANE_BITS'(i)}] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_word = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      rdata_word[8*i +: 8] = mem[{word_idx, LANE_BITS'(i)}];
    end
  end

  assign bus.hreadyout = hreadyout_c;
  assign bus.hresp     = hresp_c;
  assign bus.hrdata    = (complete && !write_q) ? rdata_word : '0;

  // Sideband inputs that never influence the response.
  logic unused_sideband;
  assign unused_sideband = ^{bus.hburst, bus.hmastlock, bus.hprot};

endmodule

// File: tb/tb_ahb_uvc_slave_mem.sv
// ----------------------------------------------------------------------------
// tb_ahb_uvc_slave_mem
// Three slave instances (WAIT_STATES 0, 2, 3) share one stimulus bus; hsel
// is routed only to the instance under test and its outputs are muxed back.
// A transfer-level model (byte array per instance) predicts data phase
// length, response and read data for every accepted transfer.
// ----------------------------------------------------------------------------
module tb_ahb_uvc_slave_mem;
  import ahb_uvc_pkg::*;

  localparam int NDUT = 3;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 2 : 3;
  endfunction

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        stall;
  logic        hready_bus;
  int          sel_dut;

  logic        ro_mux, rs_mux;
  logic [31:0] rd_mux;

  always #5 hclk = ~hclk;

  ahb_uvc_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
  ahb_uvc_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
  ahb_uvc_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

  assign if0.hsel = hsel && (sel_dut == 0);
  assign if1.hsel = hsel && (sel_dut == 1);
  assign if2.hsel = hsel && (sel_dut == 2);
  assign {if0.haddr, if1.haddr, if2.haddr}    = {3{haddr}};
  assign {if0.hburst, if1.hburst, if2.hburst} = {3{hburst}};
  assign {if0.hmastlock, if1.hmastlock, if2.hmastlock} = 3'b000;
  assign {if0.hprot, if1.hprot, if2.hprot}    = {3{4'h3}};
  assign {if0.hsize, if1.hsize, if2.hsize}    = {3{hsize}};
  assign {if0.htrans, if1.htrans, if2.htrans} = {3{htrans}};
  assign {if0.hwrite, if1.hwrite, if2.hwrite} = {3{hwrite}};
  assign {if0.hwdata, if1.hwdata, if2.hwdata} = {3{hwdata}};
  assign {if0.hready, if1.hready, if2.hready} = {3{hready_bus}};

  ahb_uvc_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                      .WAIT_STATES(0))
    u_dut0 (.hclk(hclk), .hreset(hreset), .bus(if0.slave));
  ahb_uvc_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                      .WAIT_STATES(2))
    u_dut1 (.hclk(hclk), .hreset(hreset), .bus(if1.slave));
  ahb_uvc_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024),
                      .WAIT_STATES(3))
    u_dut2 (.hclk(hclk), .hreset(hreset), .bus(if2.slave));

  always_comb begin
    ro_mux = if0.hreadyout;
    rs_mux = if0.hresp;
    rd_mux = if0.hrdata;
    if (sel_dut == 1) begin
      ro_mux = if1.hreadyout;
      rs_mux = if1.hresp;
      rd_mux = if1.hrdata;
    end else if (sel_dut == 2) begin
      ro_mux = if2.hreadyout;
      rs_mux = if2.hresp;
      rd_mux = if2.hrdata;
    end
  end

  assign hready_bus = !stall && ro_mux;

  // --------------------------------------------------------------------------
  // Scoreboard counters and check
  // --------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain byte memories and the legality rules
  // --------------------------------------------------------------------------
  logic [7:0]  mdl [NDUT][1024];
  logic [31:0] last_rdata;
  int          dp_count = 0;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
  } item_t;

  item_t items[$];

  function automatic bit model_err(input item_t it);
    int unsigned nbytes = 32'd1 << it.size;
    return (it.addr >= 32'd1024) || ((it.addr % nbytes) != 0) || (nbytes > 4);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int unsigned b = a & ~32'd3;
    return {mdl[sel_dut][b+3], mdl[sel_dut][b+2],
            mdl[sel_dut][b+1], mdl[sel_dut][b]};
  endfunction

  task automatic model_write(input item_t it);
    int unsigned lane = it.addr % 4;
    for (int i = 0; i < (1 << it.size); i++) begin
      mdl[sel_dut][it.addr + i] = it.wdata[8*(lane + i) +: 8];
    end
  endtask

  task automatic push(input logic sel, input logic [1:0] tr,
                      input logic [31:0] a, input logic [2:0] sz,
                      input logic w, input logic [31:0] wd);
    item_t it;
    it.sel = sel; it.trans = tr; it.addr = a; it.size = sz;
    it.write = w; it.wdata = wd;
    items.push_back(it);
  endtask

  task automatic drive(input item_t it);
    hsel   = it.sel;
    htrans = it.trans;
    haddr  = it.addr;
    hsize  = it.size;
    hwrite = it.write;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = IDLE;
  endtask

  task automatic finish_phase(input item_t d, input int cyc,
                              input logic rs, input logic [31:0] rd);
    bit    err = model_err(d);
    string id  = $sformatf("d%0d_%s_%0h", sel_dut, d.write ? "wr" : "rd",
                           d.addr);
    check({id, "_len"}, 64'(cyc), err ? 64'd2 : 64'(ws_of(sel_dut) + 1));
    check({id, "_resp"}, 64'(rs), 64'(err));
    check({id, "_rdata"}, 64'(rd),
          (!err && !d.write) ? 64'(model_word(d.addr)) : 64'd0);
    if (!err && d.write) model_write(d);
    if (!err && !d.write) last_rdata = rd;
  endtask

  // Presents the queued address phases with AHB pipelining against the
  // selected instance and scores each data phase as it completes.
  task automatic run_pipe();
    item_t       d;
    bit          dp    = 0;
    int          cyc   = 0;
    int          ai    = 0;
    int          guard = 0;
    int          n     = items.size();
    logic        ro, rs;
    logic [31:0] rd;
    forever begin
      @(negedge hclk);
      ro = hready_bus;
      rs = rs_mux;
      rd = rd_mux;
      if (dp) begin
        if (cyc == 0 && d.write) hwdata = d.wdata;
        cyc++;
        if (ro) begin
          finish_phase(d, cyc, rs, rd);
          dp = 0;
        end else begin
          check($sformatf("d%0d_stretch_resp_%0h", sel_dut, d.addr),
                64'(rs), 64'(model_err(d)));
          check($sformatf("d%0d_stretch_rdata_%0h", sel_dut, d.addr),
                64'(rd), 64'd0);
        end
      end
      if (ai >= n && !dp) break;
      if (ai < n) drive(items[ai]);
      else drive_idle();
      if (ro && ai < n) begin
        if (items[ai].sel && items[ai].trans[1]) begin
          d   = items[ai];
          dp  = 1;
          cyc = 0;
          dp_count++;
        end
        ai++;
      end
      guard++;
      if (guard > 64 * (n + 1)) begin
        check("pipe_timeout_items_left", 64'(n - ai + int'(dp)), 64'd0);
        break;
      end
    end
    drive_idle();
    items.delete();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved;
    logic [31:0] bw [4];
    int          base;

    hreset = 1'b1;
    stall  = 1'b0;
    sel_dut = 0;
    hsel = 1'b0; haddr = '0; hburst = HBURST_SINGLE; hsize = HSIZE_WORD;
    htrans = IDLE; hwrite = 1'b0; hwdata = '0;

    // Reset values on every instance.
    repeat (2) @(negedge hclk);
    for (int k = 0; k < NDUT; k++) begin
      sel_dut = k;
      #1;
      check($sformatf("d%0d_reset_hreadyout", k), 64'(ro_mux), 64'd1);
      check($sformatf("d%0d_reset_hresp", k), 64'(rs_mux), 64'd0);
      check($sformatf("d%0d_reset_hrdata", k), 64'(rd_mux), 64'd0);
    end
    @(negedge hclk);
    hreset = 1'b0;

    // Give every word of the low 128 bytes a known value.
    for (int k = 0; k < NDUT; k++) begin
      sel_dut = k;
      for (int i = 0; i < 32; i++) push(1, NONSEQ, 32'(4 * i), HSIZE_WORD, 1, $urandom);
      run_pipe();
    end

    // Zero wait states: back-to-back word write then read of 0x40.
    sel_dut = 0;
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 1, 32'hDEADBEEF);
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    check("d0_b2b_readback", 64'(last_rdata), 64'hDEADBEEF);

    // Two wait states: byte merge, out-of-range read, misaligned halfword.
    sel_dut = 1;
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 1, 32'h11223344);
    push(1, NONSEQ, 32'h43, HSIZE_BYTE, 1, 32'hAA5A5A5A);
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    check("d1_byte_merge", 64'(last_rdata), 64'hAA223344);
    push(1, NONSEQ, 32'h400, HSIZE_WORD, 0, 32'h0);
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    check("d1_okay_after_error", 64'(last_rdata), 64'hAA223344);
    push(1, NONSEQ, 32'h41, HSIZE_HALF, 1, 32'hFFFFFFFF);
    push(1, NONSEQ, 32'h40, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    check("d1_misaligned_no_write", 64'(last_rdata), 64'hAA223344);

    // Three wait states: reset in the middle of a write's wait states.
    sel_dut = 2;
    push(1, NONSEQ, 32'h10, HSIZE_WORD, 1, 32'h5A5A0110);
    run_pipe();
    saved = 32'h5A5A0110;
    @(negedge hclk);
    hsel = 1'b1; htrans = NONSEQ; haddr = 32'h10; hsize = HSIZE_WORD; hwrite = 1'b1;
    @(negedge hclk);
    drive_idle();
    hwdata = 32'hCAFEF00D;
    check("d2_pre_reset_in_wait", 64'(ro_mux), 64'd0);
    @(negedge hclk);
    #2 hreset = 1'b1;
    #1;
    check("d2_midwait_reset_hreadyout", 64'(ro_mux), 64'd1);
    check("d2_midwait_reset_hresp", 64'(rs_mux), 64'd0);
    check("d2_midwait_reset_hrdata", 64'(rd_mux), 64'd0);
    @(negedge hclk);
    hreset = 1'b0;
    push(1, NONSEQ, 32'h10, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    check("d2_aborted_write_discarded", 64'(last_rdata), 64'(saved));

    // Another slave stalls the bus while this one is selected.
    sel_dut = 1;
    @(negedge hclk);
    stall = 1'b1; hburst = HBURST_INCR4;
    hsel = 1'b1; htrans = NONSEQ; haddr = 32'h60; hsize = HSIZE_WORD; hwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check($sformatf("d1_stall_hreadyout_%0d", i), 64'(ro_mux), 64'd1);
      check($sformatf("d1_stall_hrdata_%0d", i), 64'(rd_mux), 64'd0);
    end
    stall = 1'b0;
    drive_idle();
    @(negedge hclk);
    check("d1_stall_no_phase", 64'(ro_mux), 64'd1);

    // INCR4 write and read bursts with BUSY, IDLE and unselected beats.
    for (int i = 0; i < 4; i++) bw[i] = $urandom;
    base = dp_count;
    push(1, NONSEQ, 32'h60, HSIZE_WORD, 1, bw[0]);
    push(1, SEQ,    32'h64, HSIZE_WORD, 1, bw[1]);
    push(1, BUSY,   32'h68, HSIZE_WORD, 1, 32'h0);
    push(1, SEQ,    32'h68, HSIZE_WORD, 1, bw[2]);
    push(1, IDLE,   32'h6C, HSIZE_WORD, 1, 32'h0);
    push(1, SEQ,    32'h6C, HSIZE_WORD, 1, bw[3]);
    push(1, NONSEQ, 32'h60, HSIZE_WORD, 0, 32'h0);
    push(1, BUSY,   32'h64, HSIZE_WORD, 0, 32'h0);
    push(1, SEQ,    32'h64, HSIZE_WORD, 0, 32'h0);
    push(1, SEQ,    32'h68, HSIZE_WORD, 0, 32'h0);
    push(0, SEQ,    32'h6C, HSIZE_WORD, 0, 32'h0);
    push(1, SEQ,    32'h6C, HSIZE_WORD, 0, 32'h0);
    run_pipe();
    hburst = HBURST_SINGLE;
    check("d1_burst_data_phases", 64'(dp_count - base), 64'd8);
    check("d1_burst_last_beat", 64'(last_rdata), 64'(bw[3]));

    // Randomized mixed traffic on every instance.
    for (int k = 0; k < NDUT; k++) begin
      sel_dut = k;
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 255);
        else a = $urandom_range(0, 127);
        push($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), a,
             3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      end
      run_pipe();
    end

    repeat (2) @(negedge hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
